// File: rtl/pc_fetch_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_if
// Fetch-side bundle between the PC/fetch-request generator and its
// environment (pipeline control, decode redirect, instruction memory).
//
// Signals:
//   stall         pipeline stall, holds the current request
//   flush         exception/flush redirect request
//   flush_pc      flush target
//   branch_valid  taken branch/jump from decode
//   branch_target branch/jump target
//   fetch_ready   instruction memory accepts the current request
//   pc            current fetch address
//   ce            instruction memory chip enable (request valid)
//   misaligned    one-cycle pulse: a captured redirect target was misaligned
//   bad_addr      offending target, meaningful while misaligned=1
//
// Modports:
//   master  the fetch unit (drives pc/ce/misaligned/bad_addr)
//   slave   the environment (drives control, redirect and ready)
// ----------------------------------------------------------------------------
interface pc_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              fetch_ready;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              misaligned;
    logic [ADDR_W-1:0] bad_addr;

    modport master (
        input  stall,
        input  flush,
        input  flush_pc,
        input  branch_valid,
        input  branch_target,
        input  fetch_ready,
        output pc,
        output ce,
        output misaligned,
        output bad_addr
    );

    modport slave (
        output stall,
        output flush,
        output flush_pc,
        output branch_valid,
        output branch_target,
        output fetch_ready,
        input  pc,
        input  ce,
        input  misaligned,
        input  bad_addr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and fetch-request generator for the CPU front end. Drives
// the instruction-memory address and chip enable, advances only on an
// accepted handshake, buffers a redirect that arrives while the request is
// not accepted, and substitutes EXC_VECTOR for misaligned redirect targets.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous, active-high reset (overrides every other input)
//   io_fetch  pc_fetch_if.master: stall/flush/branch/ready in,
//             pc/ce/misaligned/bad_addr out (all outputs registered)
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h00000020)
) (
    input logic         clk,
    input logic         rst,
    pc_fetch_if.master  io_fetch
);

    // Low address bits that must be zero for an aligned instruction address.
    // With INST_BYTES=1 the mask is zero and nothing is ever misaligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    typedef enum logic {
        StBoot = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic              r_mis;
    logic [ADDR_W-1:0] r_bad;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_pc;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_mis_nxt;
    logic [ADDR_W-1:0] w_bad_nxt;
    logic              w_pend_v_nxt;
    logic [ADDR_W-1:0] w_pend_pc_nxt;

    logic              w_accept;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_tgt_mis;
    logic [ADDR_W-1:0] w_tgt_chk;
    logic              w_cap_pc;
    logic              w_cap_pend;

    assign w_accept  = r_ce & io_fetch.fetch_ready & ~io_fetch.stall;

    // Every capture takes flush_pc when flushing, otherwise the branch target,
    // so one shared alignment checker serves both redirect sources.
    assign w_tgt     = io_fetch.flush ? io_fetch.flush_pc : io_fetch.branch_target;
    assign w_tgt_mis = (w_tgt & ALIGN_MASK) != '0;
    assign w_tgt_chk = w_tgt_mis ? EXC_VECTOR : w_tgt;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_mis_nxt     = 1'b0;
        w_bad_nxt     = r_bad;
        w_pend_v_nxt  = r_pend_v;
        w_pend_pc_nxt = r_pend_pc;
        w_cap_pc      = 1'b0;
        w_cap_pend    = 1'b0;

        unique case (r_state)
            StBoot: begin
                // pc already holds RESET_VECTOR; only a flush can change it.
                w_state_nxt = StRun;
                if (io_fetch.flush) begin
                    w_cap_pc     = 1'b1;
                    w_pend_v_nxt = 1'b0;
                end
            end
            StRun: begin
                if (io_fetch.flush) begin
                    // Any concurrent branch is dropped, not buffered.
                    w_cap_pc     = 1'b1;
                    w_pend_v_nxt = 1'b0;
                end else if (w_accept && io_fetch.branch_valid) begin
                    // A fresh branch supersedes any older pending redirect.
                    w_cap_pc     = 1'b1;
                    w_pend_v_nxt = 1'b0;
                end else if (w_accept && r_pend_v) begin
                    w_pc_nxt     = r_pend_pc;
                    w_pend_v_nxt = 1'b0;
                end else if (w_accept) begin
                    w_pc_nxt = r_pc + PC_INC;
                end else if (io_fetch.branch_valid) begin
                    w_cap_pend = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StBoot;
            end
        endcase

        // The flag is raised when a target is captured, not when applied.
        if (w_cap_pc || w_cap_pend) begin
            w_mis_nxt = w_tgt_mis;
            if (w_tgt_mis) begin
                w_bad_nxt = w_tgt;
            end
        end
        if (w_cap_pc) begin
            w_pc_nxt = w_tgt_chk;
        end
        if (w_cap_pend) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = w_tgt_chk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StBoot;
            r_pc      <= RESET_VECTOR;
            r_ce      <= 1'b0;
            r_mis     <= 1'b0;
            r_bad     <= '0;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ce      <= (w_state_nxt == StRun);
            r_mis     <= w_mis_nxt;
            r_bad     <= w_bad_nxt;
            r_pend_v  <= w_pend_v_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    assign io_fetch.pc         = r_pc;
    assign io_fetch.ce         = r_ce;
    assign io_fetch.misaligned = r_mis;
    assign io_fetch.bad_addr   = r_bad;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Scoreboard bench for pc_fetch_unit. Stimulus pushes the expected address
// (and misalignment status) of every fetch it expects to be accepted; a
// monitor per DUT pops and compares on each accepted handshake.
//   dut_a: ADDR_W=32, INST_BYTES=4
//   dut_b: ADDR_W=16, INST_BYTES=2 (address wrap and 16-bit misalignment)
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    pc_fetch_if #(.ADDR_W(32)) bus_a ();
    pc_fetch_if #(.ADDR_W(16)) bus_b ();

    pc_fetch_unit #(
        .ADDR_W       (32),
        .INST_BYTES   (4),
        .RESET_VECTOR (32'h00000000),
        .EXC_VECTOR   (32'h00000020)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (bus_a.master)
    );

    pc_fetch_unit #(
        .ADDR_W       (16),
        .INST_BYTES   (2),
        .RESET_VECTOR (16'h0000),
        .EXC_VECTOR   (16'h0020)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic st, input logic fl, input logic [31:0] fpc,
                           input logic bv, input logic [31:0] bt, input logic rdy);
        bus_a.stall         = st;
        bus_a.flush         = fl;
        bus_a.flush_pc      = fpc;
        bus_a.branch_valid  = bv;
        bus_a.branch_target = bt;
        bus_a.fetch_ready   = rdy;
    endtask

    task automatic drive_b(input logic st, input logic fl, input logic [15:0] fpc,
                           input logic bv, input logic [15:0] bt, input logic rdy);
        bus_b.stall         = st;
        bus_b.flush         = fl;
        bus_b.flush_pc      = fpc;
        bus_b.branch_valid  = bv;
        bus_b.branch_target = bt;
        bus_b.fetch_ready   = rdy;
    endtask

    task automatic exp_a(input logic [31:0] p, input logic m = 1'b0,
                         input logic [31:0] b = 32'h0);
        q_a.push_back('{pc: p, mis: m, bad: b});
    endtask

    task automatic exp_b(input logic [31:0] p, input logic m = 1'b0,
                         input logic [31:0] b = 32'h0);
        q_b.push_back('{pc: p, mis: m, bad: b});
    endtask

    // Monitors: compare on every accepted handshake, away from the edge.
    always @(negedge clk) begin
        if (!rst && bus_a.ce && bus_a.fetch_ready && !bus_a.stall) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_fetch: got pc %h, expected no fetch", bus_a.pc);
            end else begin
                e_a = q_a.pop_front();
                check("a_pc", bus_a.pc, e_a.pc);
                check("a_misaligned", {31'b0, bus_a.misaligned}, {31'b0, e_a.mis});
                if (e_a.mis) check("a_bad_addr", bus_a.bad_addr, e_a.bad);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.ce && bus_b.fetch_ready && !bus_b.stall) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_fetch: got pc %h, expected no fetch", bus_b.pc);
            end else begin
                e_b = q_b.pop_front();
                check("b_pc", {16'b0, bus_b.pc}, e_b.pc);
                check("b_misaligned", {31'b0, bus_b.misaligned}, {31'b0, e_b.mis});
                if (e_b.mis) check("b_bad_addr", {16'b0, bus_b.bad_addr}, e_b.bad);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        drive_b(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        check("a_rst_ce", {31'b0, bus_a.ce}, 32'h0);
        check("a_rst_pc", bus_a.pc, 32'h0);
        check("a_rst_misaligned", {31'b0, bus_a.misaligned}, 32'h0);
        check("a_rst_bad_addr", bus_a.bad_addr, 32'h0);
        check("b_rst_ce", {31'b0, bus_b.ce}, 32'h0);

        // Release: one BOOT cycle with ce=0, then free run from 0.
        rst = 1'b0;
        tick();
        check("a_boot_exit_ce", {31'b0, bus_a.ce}, 32'h1);
        exp_a(32'h0);   tick();
        exp_a(32'h4);   tick();
        // Stall 3 cycles at 0x8 with a branch pulse to 0x100.
        drive_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1); tick();
        check("a_stall_pc_hold", bus_a.pc, 32'h8);
        drive_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);   tick();
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_a(32'h8);   tick();
        exp_a(32'h100); tick();
        // Memory not ready at 0x104, two branches: the later one wins.
        drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0); tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0); tick();
        check("a_notready_pc_hold", bus_a.pc, 32'h104);
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_a(32'h104); tick();
        exp_a(32'h300); tick();
        // Pending branch, then flush+stall+branch: flush wins, pending cleared.
        drive_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);  tick();
        drive_a(1'b1, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1); tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_a(32'h80);  tick();
        // Misaligned branch target 0x102 -> EXC_VECTOR with a one-cycle flag.
        drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
        exp_a(32'h84);  tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_a(32'h20, 1'b1, 32'h102); tick();
        exp_a(32'h24);  tick();
        // Accept with both pending and new branch: the new branch is used.
        drive_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1); tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1);
        exp_a(32'h28);  tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_a(32'h700); tick();
        exp_a(32'h704); tick();
        // Leave a pending redirect, then reset mid-operation: it must be lost.
        drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0); tick();
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);   tick();
        check("a_midrst_ce", {31'b0, bus_a.ce}, 32'h0);
        check("a_midrst_pc", bus_a.pc, 32'h0);
        rst = 1'b0;
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);   tick();
        exp_a(32'h0);   tick();
        exp_a(32'h4);   tick();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // 16-bit instance: flush near the top, wrap through 0xFFFE.
        drive_b(1'b0, 1'b1, 16'hFFFC, 1'b0, 16'h0, 1'b0); tick();
        drive_b(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        exp_b(32'hFFFC); tick();
        exp_b(32'hFFFE); tick();
        exp_b(32'h0000); tick();
        drive_b(1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b1);
        exp_b(32'h0002); tick();
        drive_b(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        exp_b(32'h0020, 1'b1, 32'h0003); tick();
        exp_b(32'h0022); tick();
        drive_b(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();

        check("a_queue_drained", q_a.size(), 32'h0);
        check("b_queue_drained", q_b.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
